axi_read_arbiter: RTL and testbench
===================================

// Module: axi_read_arbiter
// PURPOSE
//   Shares one AXI4 read master port among NUM_REQ read requesters (req 0 = instruction fetch unit, others = load/DMA).
//   Round-robin arbitration; one outstanding transaction at a time; grant held from AR accept through last R beat.
//   Sits between the fetch/load units and the memory-side AXI interconnect.
// PARAMETERS
//   NUM_REQ  2   number of requester ports (>=2)
//   ADDR_W   32  address width
//   DATA_W   32  read data width
//   ID_W     4   AXI ID width; must satisfy 2**ID_W >= NUM_REQ
// PORTS
//   s_aclk         in   1               single clock, all logic rising-edge
//   s_areset       in   1               asynchronous, active-high reset
//   s_axi_araddr   in   NUM_REQ*ADDR_W  per-requester AR address, requester i at [i*ADDR_W +: ADDR_W]
//   s_axi_arburst  in   NUM_REQ*2       per-requester burst type
//   s_axi_arlen    in   NUM_REQ*8       per-requester burst length-1
//   s_axi_arsize   in   NUM_REQ*3       per-requester beat size
//   s_axi_arid     in   NUM_REQ*ID_W    per-requester transaction ID
//   s_axi_arvalid  in   NUM_REQ         per-requester AR valid
//   s_axi_arready  out  NUM_REQ         per-requester AR ready (one-hot or zero)
//   s_axi_rdata    out  DATA_W          read data, shared by all requesters
//   s_axi_rid      out  ID_W            requester's original ARID for the current transaction
//   s_axi_rresp    out  2               read response, shared
//   s_axi_rlast    out  1               last beat, shared
//   s_axi_rvalid   out  NUM_REQ         per-requester R valid (one-hot or zero)
//   s_axi_rready   in   NUM_REQ         per-requester R ready
//   m_axi_araddr/arburst/arlen/arsize/arid  out  ADDR_W/2/8/3/ID_W  registered AR fields to memory
//   m_axi_arvalid  out  1               AR valid to memory
//   m_axi_arready  in   1               AR ready from memory
//   m_axi_rdata/rid/rresp/rlast  in  DATA_W/ID_W/2/1  R channel from memory
//   m_axi_rvalid   in   1               R valid from memory
//   m_axi_rready   out  1               R ready to memory
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, grant=0, last_grant=NUM_REQ-1 (req 0 highest priority),
//     all m_axi_* AR registers 0, m_axi_arvalid=0; all outputs 0 while s_areset is high.
//   FSM IDLE -> ADDR -> DATA -> IDLE.
//   IDLE: winner = first requester with s_axi_arvalid set, scanning from (last_grant+1) mod NUM_REQ upward with wrap.
//     s_axi_arready[winner]=1 combinationally in IDLE only; on that edge: latch winner's AR fields into m_axi_* regs,
//     m_axi_arid <= winner index zero-extended, save original ARID, grant<=winner, m_axi_arvalid<=1, go ADDR.
//     Latency: s_axi_arvalid high in cycle N -> m_axi_arvalid high in cycle N+1. No valid requester: stay IDLE.
//   ADDR: hold all m_axi_ar* stable until m_axi_arvalid&&m_axi_arready; then m_axi_arvalid<=0, go DATA.
//   DATA: combinational route: s_axi_rvalid[grant]=m_axi_rvalid, m_axi_rready=s_axi_rready[grant];
//     s_axi_rdata/rresp/rlast copy m_axi_*; s_axi_rid = saved original ARID. Non-granted rvalid bits stay 0.
//     On m_axi_rvalid&&m_axi_rready&&m_axi_rlast: last_grant<=grant, go IDLE. Non-last beats stay in DATA.
//   Outside DATA: m_axi_rready=0, all s_axi_rvalid=0; stray m_axi_rvalid is ignored (not consumed).
//   s_axi_arready is never high outside IDLE; a requester whose arvalid is pending waits, never dropped.
//   Requester deasserting arvalid before grant (protocol violation) simply loses arbitration; no error.
//   m_axi_rid is not checked; routing is by held grant only (single outstanding).
//   Minimum gap: last R beat in cycle N -> next s_axi_arready at earliest cycle N+1.
//   Reset mid-transaction: FSM, grant and pointer clear immediately; in-flight burst is abandoned.
// TESTING
//   1 Assert s_areset mid-cycle -> all outputs 0 immediately, no clock edge needed; release -> IDLE, req 0 priority.
//   2 Req0 araddr=0x0000_0100, arid=5, arlen=0; memory arready=1, rdata=0xDEADBEEF rlast=1 -> s_axi_arready[0] same
//     cycle, m_axi_arvalid next cycle, m_axi_araddr=0x100, m_axi_arid=0; s_axi_rvalid=2'b01, rid=5, rdata=0xDEADBEEF.
//   3 Req0 and req1 arvalid held continuously, single-beat reads -> grant order 0,1,0,1; no cycle with both arready set.
//   4 Req1 arlen=3 with req0 arriving mid-burst -> 4 beats to req1 only, req0 granted only after 4th (rlast) beat.
//   5 Req1 drops s_axi_rready for 3 cycles mid-burst -> m_axi_rready low those cycles; no beat lost or duplicated.
//   6 m_axi_rvalid=1 while IDLE/ADDR, m_axi_arready held low 5 cycles -> m_axi_rready=0, AR fields stable throughout.

Source files
------------

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read master among NUM_REQ requesters.
// One outstanding transaction; grant is held from AR accept until the last R beat.
module axi_read_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4
) (
    input  logic                      s_aclk,
    input  logic                      s_areset,
    input  logic [NUM_REQ*ADDR_W-1:0] s_axi_araddr,
    input  logic [NUM_REQ*2-1:0]      s_axi_arburst,
    input  logic [NUM_REQ*8-1:0]      s_axi_arlen,
    input  logic [NUM_REQ*3-1:0]      s_axi_arsize,
    input  logic [NUM_REQ*ID_W-1:0]   s_axi_arid,
    input  logic [NUM_REQ-1:0]        s_axi_arvalid,
    output logic [NUM_REQ-1:0]        s_axi_arready,
    output logic [DATA_W-1:0]         s_axi_rdata,
    output logic [ID_W-1:0]           s_axi_rid,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic [NUM_REQ-1:0]        s_axi_rvalid,
    input  logic [NUM_REQ-1:0]        s_axi_rready,
    output logic [ADDR_W-1:0]         m_axi_araddr,
    output logic [1:0]                m_axi_arburst,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [ID_W-1:0]           m_axi_arid,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [DATA_W-1:0]         m_axi_rdata,
    input  logic [ID_W-1:0]           m_axi_rid,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        burst;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [ID_W-1:0]   id;
    } ar_req_t;

    state_t        state, state_nxt;
    logic [GW-1:0] grant, last_grant, winner;
    logic          found;
    logic [ID_W-1:0] saved_rid;
    ar_req_t       win_req;
    int            idx;
    logic          r_done;

    // Round-robin scan starting just after the previous grant, wrapping.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && s_axi_arvalid[GW'(idx)]) begin
                found  = 1'b1;
                winner = GW'(idx);
            end
        end
    end

    always_comb begin
        win_req.addr  = s_axi_araddr[int'(winner)*ADDR_W +: ADDR_W];
        win_req.burst = s_axi_arburst[int'(winner)*2 +: 2];
        win_req.len   = s_axi_arlen[int'(winner)*8 +: 8];
        win_req.size  = s_axi_arsize[int'(winner)*3 +: 3];
        win_req.id    = s_axi_arid[int'(winner)*ID_W +: ID_W];
    end

    assign r_done = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    always_ff @(posedge s_aclk or posedge s_areset) begin
        if (s_areset) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = ADDR;
            ADDR:    if (m_axi_arvalid && m_axi_arready) state_nxt = DATA;
            DATA:    if (r_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge s_aclk or posedge s_areset) begin
        if (s_areset) begin
            grant         <= '0;
            last_grant    <= GW'(NUM_REQ - 1);
            saved_rid     <= '0;
            m_axi_araddr  <= '0;
            m_axi_arburst <= '0;
            m_axi_arlen   <= '0;
            m_axi_arsize  <= '0;
            m_axi_arid    <= '0;
            m_axi_arvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    m_axi_araddr  <= win_req.addr;
                    m_axi_arburst <= win_req.burst;
                    m_axi_arlen   <= win_req.len;
                    m_axi_arsize  <= win_req.size;
                    // Downstream sees the requester index; the original ID is restored on R.
                    m_axi_arid    <= ID_W'(winner);
                    saved_rid     <= win_req.id;
                    grant         <= winner;
                    m_axi_arvalid <= 1'b1;
                end
                ADDR: if (m_axi_arready) m_axi_arvalid <= 1'b0;
                DATA: if (r_done) last_grant <= grant;
                default: ;
            endcase
        end
    end

    // Combinational outputs are forced low during reset as well.
    always_comb begin
        s_axi_arready = '0;
        s_axi_rvalid  = '0;
        m_axi_rready  = 1'b0;
        s_axi_rdata   = '0;
        s_axi_rresp   = '0;
        s_axi_rlast   = 1'b0;
        s_axi_rid     = '0;
        if (!s_areset) begin
            if (state == IDLE && found) s_axi_arready[winner] = 1'b1;
            if (state == DATA) begin
                s_axi_rvalid[grant] = m_axi_rvalid;
                m_axi_rready        = s_axi_rready[grant];
                s_axi_rdata         = m_axi_rdata;
                s_axi_rresp         = m_axi_rresp;
                s_axi_rlast         = m_axi_rlast;
                s_axi_rid           = saved_rid;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: vector table of isolated transactions
// plus hand-written sequences for arbitration, stalls, stray beats and reset.
module tb_axi_read_arbiter;
    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic s_aclk = 1'b0;
    logic s_areset = 1'b1;
    logic [NR*AW-1:0] s_axi_araddr;
    logic [NR*2-1:0]  s_axi_arburst;
    logic [NR*8-1:0]  s_axi_arlen;
    logic [NR*3-1:0]  s_axi_arsize;
    logic [NR*IW-1:0] s_axi_arid;
    logic [NR-1:0]    s_axi_arvalid;
    logic [NR-1:0]    s_axi_arready;
    logic [DW-1:0]    s_axi_rdata;
    logic [IW-1:0]    s_axi_rid;
    logic [1:0]       s_axi_rresp;
    logic             s_axi_rlast;
    logic [NR-1:0]    s_axi_rvalid;
    logic [NR-1:0]    s_axi_rready;
    logic [AW-1:0]    m_axi_araddr;
    logic [1:0]       m_axi_arburst;
    logic [7:0]       m_axi_arlen;
    logic [2:0]       m_axi_arsize;
    logic [IW-1:0]    m_axi_arid;
    logic             m_axi_arvalid;
    logic             m_axi_arready;
    logic [DW-1:0]    m_axi_rdata;
    logic [IW-1:0]    m_axi_rid;
    logic [1:0]       m_axi_rresp;
    logic             m_axi_rlast;
    logic             m_axi_rvalid;
    logic             m_axi_rready;

    int checks = 0;
    int errors = 0;

    always #5 s_aclk = ~s_aclk;

    axi_read_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
        .s_aclk(s_aclk), .s_areset(s_areset),
        .s_axi_araddr(s_axi_araddr), .s_axi_arburst(s_axi_arburst), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arid(s_axi_arid), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rid(s_axi_rid),
        .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid),
        .s_axi_rready(s_axi_rready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arburst(m_axi_arburst), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arid(m_axi_arid), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rid(m_axi_rid),
        .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    typedef struct {
        int          req;
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [31:0] data;
        logic [1:0]  exp_onehot;
        logic [3:0]  exp_marid;
        logic [3:0]  exp_rid;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge s_aclk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_ar(input int r, input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len);
        s_axi_araddr[r*AW +: AW] = addr;
        s_axi_arid[r*IW +: IW]   = id;
        s_axi_arlen[r*8 +: 8]    = len;
        s_axi_arburst[r*2 +: 2]  = 2'b01;
        s_axi_arsize[r*3 +: 3]   = 3'b010;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int beat;
        logic [1:0] exp;
        s_axi_araddr = '0; s_axi_arburst = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arid = '0; s_axi_arvalid = 2'b11; s_axi_rready = 2'b11;
        m_axi_arready = 1'b1; m_axi_rdata = '0; m_axi_rid = '0; m_axi_rresp = '0;
        m_axi_rlast = 1'b0; m_axi_rvalid = 1'b0;

        vecs[0] = '{0, 32'h0000_0100, 4'h5, 8'd0, 32'hDEAD_BEEF, 2'b01, 4'h0, 4'h5};
        vecs[1] = '{1, 32'h0000_2000, 4'hA, 8'd1, 32'h1111_0000, 2'b10, 4'h1, 4'hA};
        vecs[2] = '{0, 32'h0000_0000, 4'h0, 8'd2, 32'h2222_0000, 2'b01, 4'h0, 4'h0};
        vecs[3] = '{1, 32'hFFFF_FFFC, 4'hF, 8'd0, 32'h3333_0000, 2'b10, 4'h1, 4'hF};

        // Reset held: combinational grant must stay low even with requests pending.
        #2;
        chk("rst_arready", s_axi_arready, 2'b00);
        chk("rst_m_arvalid", m_axi_arvalid, 1'b0);
        chk("rst_m_rready", m_axi_rready, 1'b0);
        tick(); s_areset = 1'b0; settle();
        chk("rst_release_prio", s_axi_arready, 2'b01);
        s_axi_arvalid = '0;

        // Isolated transactions from the vector table.
        foreach (vecs[v]) begin
            tick();
            s_axi_arvalid = '0;
            s_axi_arvalid[vecs[v].req] = 1'b1;
            set_ar(vecs[v].req, vecs[v].addr, vecs[v].id, vecs[v].len);
            m_axi_arready = 1'b1; m_axi_rvalid = 1'b0;
            settle();
            chk("vec_arready", s_axi_arready, vecs[v].exp_onehot);
            chk("vec_m_arvalid_pre", m_axi_arvalid, 1'b0);
            tick(); s_axi_arvalid = '0; settle();
            chk("vec_m_arvalid", m_axi_arvalid, 1'b1);
            chk("vec_m_araddr", m_axi_araddr, vecs[v].addr);
            chk("vec_m_arid", m_axi_arid, vecs[v].exp_marid);
            chk("vec_m_arlen", m_axi_arlen, vecs[v].len);
            for (int b = 0; b <= int'(vecs[v].len); b++) begin
                tick();
                m_axi_rvalid = 1'b1; m_axi_rdata = vecs[v].data + b;
                m_axi_rlast = (b == int'(vecs[v].len)); m_axi_rresp = 2'b00;
                settle();
                chk("vec_rvalid", s_axi_rvalid, vecs[v].exp_onehot);
                chk("vec_rid", s_axi_rid, vecs[v].exp_rid);
                chk("vec_rdata", s_axi_rdata, vecs[v].data + b);
                chk("vec_m_rready", m_axi_rready, 1'b1);
            end
            tick(); m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        end

        // Both requesters continuously valid: strict alternation 0,1,0,1.
        set_ar(0, 32'h0000_1000, 4'h2, 8'd0);
        set_ar(1, 32'h0000_3000, 4'h9, 8'd0);
        for (int i = 0; i < 4; i++) begin
            tick(); m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; s_axi_arvalid = 2'b11; settle();
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            chk("rr_arready", s_axi_arready, exp);
            tick(); settle();
            chk("rr_addr_arready", s_axi_arready, 2'b00);
            chk("rr_m_arid", m_axi_arid, (i % 2 == 0) ? 4'h0 : 4'h1);
            tick(); m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = 32'(i); settle();
            chk("rr_rvalid", s_axi_rvalid, exp);
        end
        tick(); s_axi_arvalid = '0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;

        // Req1 4-beat burst; req0 arrives mid-burst and must wait for rlast.
        tick(); s_axi_arvalid = 2'b10; set_ar(1, 32'h0000_4000, 4'h6, 8'd3); settle();
        chk("burst_arready", s_axi_arready, 2'b10);
        tick(); s_axi_arvalid = '0; settle();
        chk("burst_m_arlen", m_axi_arlen, 8'd3);
        for (int b = 0; b < 4; b++) begin
            tick();
            m_axi_rvalid = 1'b1; m_axi_rdata = 32'h100 + b; m_axi_rlast = (b == 3);
            if (b == 1) s_axi_arvalid = 2'b01;
            settle();
            chk("burst_rvalid", s_axi_rvalid, 2'b10);
            chk("burst_rdata", s_axi_rdata, 32'h100 + b);
            chk("burst_no_arready", s_axi_arready, 2'b00);
        end
        tick(); m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; settle();
        chk("burst_req0_after", s_axi_arready, 2'b01);
        tick(); s_axi_arvalid = '0;
        tick(); m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_rdata = 32'h55; settle();
        chk("burst_req0_rvalid", s_axi_rvalid, 2'b01);
        tick(); m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;

        // Req1 backpressure: rready low for cycles 1..3 of the burst.
        tick(); s_axi_arvalid = 2'b10; set_ar(1, 32'h0000_5000, 4'h7, 8'd3); settle();
        chk("bp_arready", s_axi_arready, 2'b10);
        tick(); s_axi_arvalid = '0;
        beat = 0;
        for (int c = 0; c < 20 && beat < 4; c++) begin
            tick();
            m_axi_rvalid = 1'b1; m_axi_rdata = 32'h5500 + beat; m_axi_rlast = (beat == 3);
            s_axi_rready = (c >= 1 && c <= 3) ? 2'b00 : 2'b11;
            settle();
            chk("bp_m_rready", m_axi_rready, (c >= 1 && c <= 3) ? 1'b0 : 1'b1);
            chk("bp_rvalid", s_axi_rvalid, 2'b10);
            if (m_axi_rready) begin
                chk("bp_rdata", s_axi_rdata, 32'h5500 + beat);
                beat++;
            end
        end
        chk("bp_beats", beat, 4);
        // Memory keeps rvalid up: burst is over, so nothing more is routed or consumed.
        tick(); s_axi_rready = 2'b11; m_axi_rlast = 1'b1; settle();
        chk("bp_no_extra_rvalid", s_axi_rvalid, 2'b00);
        chk("bp_no_extra_rready", m_axi_rready, 1'b0);

        // Stray R beats during IDLE/ADDR, memory stalls AR for 5 cycles.
        s_axi_arvalid = 2'b01; set_ar(0, 32'h8000_0040, 4'h3, 8'd0);
        m_axi_arready = 1'b0; m_axi_rdata = 32'h0000_0BAD; settle();
        chk("stray_idle_rready", m_axi_rready, 1'b0);
        chk("stray_idle_rvalid", s_axi_rvalid, 2'b00);
        chk("stray_idle_arready", s_axi_arready, 2'b01);
        for (int k = 0; k < 6; k++) begin
            tick(); s_axi_arvalid = '0; m_axi_arready = (k == 5); settle();
            chk("stall_m_arvalid", m_axi_arvalid, 1'b1);
            chk("stall_m_araddr", m_axi_araddr, 32'h8000_0040);
            chk("stall_m_arid", m_axi_arid, 4'h0);
            chk("stall_m_rready", m_axi_rready, 1'b0);
            chk("stall_rvalid", s_axi_rvalid, 2'b00);
        end
        tick(); m_axi_rdata = 32'h0000_600D; settle();
        chk("stall_data_rvalid", s_axi_rvalid, 2'b01);
        chk("stall_data_rid", s_axi_rid, 4'h3);
        chk("stall_data_rdata", s_axi_rdata, 32'h0000_600D);
        tick(); m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_arready = 1'b0;

        // Reset asserted mid-transaction between clock edges.
        tick(); s_axi_arvalid = 2'b10; set_ar(1, 32'h0000_7000, 4'h4, 8'd0);
        tick(); s_axi_arvalid = 2'b11; settle();
        chk("mid_m_arvalid", m_axi_arvalid, 1'b1);
        s_areset = 1'b1; #1;
        chk("mid_rst_m_arvalid", m_axi_arvalid, 1'b0);
        chk("mid_rst_m_araddr", m_axi_araddr, 32'h0);
        chk("mid_rst_arready", s_axi_arready, 2'b00);
        tick(); s_areset = 1'b0; settle();
        chk("mid_rst_prio", s_axi_arready, 2'b01);
        s_axi_arvalid = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
